// File: rtl/alu_stream.sv
// ============================================================================
// alu_stream : 8-bit ALU behind a request register and a 3-entry result FIFO
// Revision   : 1.0
// ============================================================================
`default_nettype none

module alu_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] ctrl,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       carry,
  output logic [7:0] out,
  output logic       err
);

  localparam logic [1:0] C_DEPTH_M1 = 2'd2;

  logic       r_live;
  logic       r_s1_vld;
  logic [3:0] r_s1_ctrl;
  logic [7:0] r_s1_x;
  logic [7:0] r_s1_y;
  logic [9:0] r_mem [0:2];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [1:0] r_count;

  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_occ;
  logic [8:0] w_sum;
  logic [8:0] w_dif;
  logic [9:0] w_res;
  logic [9:0] w_head;

  // S1 always drains into the FIFO: total occupancy <= 3 guarantees room.
  assign w_occ     = {2'b00, r_s1_vld} + {1'b0, r_count};
  assign in_ready  = r_live && (w_occ < 3'd3);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_s1_vld;
  assign w_pop     = out_valid && out_ready;

  assign w_head = out_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign err    = w_head[9];
  assign carry  = w_head[8];
  assign out    = w_head[7:0];

  assign w_sum = {1'b0, r_s1_x} + {1'b0, r_s1_y};
  assign w_dif = {1'b0, r_s1_x} - {1'b0, r_s1_y};

  // Result word is {err, carry, out}.
  always_comb begin
    w_res = 10'd0;
    case (r_s1_ctrl)
      4'b0000: w_res = {1'b0, w_sum};
      4'b0001: w_res = {1'b0, w_dif};
      4'b0010: w_res = {2'b00, r_s1_x & r_s1_y};
      4'b0011: w_res = {2'b00, r_s1_x | r_s1_y};
      4'b0100: w_res = {2'b00, ~r_s1_x};
      4'b0101: w_res = {2'b00, r_s1_x ^ r_s1_y};
      4'b0110: w_res = {2'b00, ~(r_s1_x | r_s1_y)};
      4'b0111: w_res = {2'b00, r_s1_y << r_s1_x[2:0]};
      4'b1000: w_res = {2'b00, r_s1_y >> r_s1_x[2:0]};
      4'b1001: w_res = {2'b00, r_s1_x[7], r_s1_x[7:1]};
      4'b1010: w_res = {2'b00, r_s1_x[6:0], r_s1_x[7]};
      4'b1011: w_res = {2'b00, r_s1_x[0], r_s1_x[7:1]};
      4'b1100: w_res = {2'b00, (r_s1_x == r_s1_y) ? 8'h01 : 8'h00};
      default: w_res = {1'b1, 9'd0};
    endcase
  end

  // Control state: cleared asynchronously so reset takes effect without clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_ctrl <= 4'd0;
      r_s1_x    <= 8'd0;
      r_s1_y    <= 8'd0;
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_count   <= 2'd0;
    end else begin
      r_live   <= 1'b1;
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_ctrl <= ctrl;
        r_s1_x    <= x;
        r_s1_y    <= y;
      end
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == C_DEPTH_M1) ? 2'd0 : r_wr_ptr + 2'd1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == C_DEPTH_M1) ? 2'd0 : r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_res;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_stream.sv
// ============================================================================
// tb_alu_stream : directed self-checking bench for alu_stream
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_alu_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ctrl;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       carry;
  logic [7:0] out;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .carry     (carry),
    .out       (out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two back-to-back requests; expected words are {err, carry, out}.
  task automatic check_pair(input string tag,
                            input logic [3:0] c1, input logic [7:0] x1, input logic [7:0] y1,
                            input logic [9:0] e1,
                            input logic [3:0] c2, input logic [7:0] x2, input logic [7:0] y2,
                            input logic [9:0] e2);
    out_ready = 1'b1;
    in_valid = 1'b1; ctrl = c1; x = x1; y = y1;
    tick();
    ctrl = c2; x = x2; y = y2;
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_a"}, {21'd0, out_valid, err, carry, out}, {21'd0, 1'b1, e1});
    tick();
    check_eq({tag, "_b"}, {21'd0, out_valid, err, carry, out}, {21'd0, 1'b1, e2});
    tick();
    check_eq({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Sends x = 1..n with ctrl=add, y=yv; out_ready held low for the first `hold` cycles.
  task automatic run_stream(input string tag, input int n, input int hold, input logic [7:0] yv);
    int n_acc = 0, n_pop = 0, cyc = 0;
    int first_acc = -1, last_acc = -1, first_pop = -1, last_pop = -1;
    int unstable = 0, stalls = 0;
    logic a, p;
    ctrl = 4'b0000; y = yv; x = 8'd1; in_valid = 1'b1;
    while (n_pop < n && cyc < 200) begin
      if (hold > 0 && cyc == hold) begin
        check_eq({tag, "_acc_held"}, n_acc, 32'd3);
        check_eq({tag, "_rdy_held"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_head_unstable"}, unstable, 32'd0);
      end
      out_ready = (cyc >= hold);
      if (cyc < hold && out_valid && out !== 8'd1 + yv) unstable++;
      if (in_valid && !in_ready) stalls++;
      a = in_valid && in_ready;
      p = out_valid && out_ready;
      if (p) begin
        check_eq({tag, "_data"}, {24'd0, out}, {24'd0, 8'(n_pop + 1) + yv});
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
      end
      tick();
      if (a) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        if (n_acc < n) x = 8'(n_acc + 1);
        else in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_done"}, n_pop, n);
    check_eq({tag, "_pop_span"}, last_pop - first_pop, n - 1);
    if (hold == 0) begin
      check_eq({tag, "_acc_span"}, last_acc - first_acc, n - 1);
      check_eq({tag, "_stalls"}, stalls, 32'd0);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl = 4'd0; x = 8'd0; y = 8'd0;
    #2;
    check_eq("rst_outputs", {20'd0, in_ready, out_valid, carry, err, out}, 32'd0);
    tick(); tick();
    check_eq("rst_hold", {30'd0, in_ready, out_valid}, 32'd0);

    // Release with a request already waiting: no accept on the first edge.
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; ctrl = 4'b0000; x = 8'hFF; y = 8'h01;
    tick();
    check_eq("first_edge_rdy", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    in_valid = 1'b0;
    check_eq("add_latency", {31'd0, out_valid}, 32'd0);
    tick();
    check_eq("add_ovf", {21'd0, out_valid, err, carry, out}, {21'd0, 1'b1, 10'h100});
    tick();
    check_eq("add_drain", {31'd0, out_valid}, 32'd0);

    check_pair("sub_asr", 4'b0001, 8'h03, 8'h05, 10'h1FE, 4'b1001, 8'h80, 8'h00, 10'h0C0);
    check_pair("undef_eq", 4'b1110, 8'hAA, 8'h55, 10'h200, 4'b1100, 8'h5A, 8'h5A, 10'h001);
    check_pair("and_or",  4'b0010, 8'hF0, 8'h3C, 10'h030, 4'b0011, 8'hF0, 8'h3C, 10'h0FC);
    check_pair("not_xor", 4'b0100, 8'h5A, 8'h00, 10'h0A5, 4'b0101, 8'h0F, 8'hFF, 10'h0F0);
    check_pair("nor_shl", 4'b0110, 8'h0F, 8'h30, 10'h0C0, 4'b0111, 8'h03, 8'h81, 10'h008);
    check_pair("shr_rol", 4'b1000, 8'h0B, 8'h81, 10'h010, 4'b1010, 8'h81, 8'h00, 10'h003);
    check_pair("ror_neq", 4'b1011, 8'h81, 8'h00, 10'h0C0, 4'b1100, 8'h01, 8'h02, 10'h000);
    check_pair("add_ff",  4'b0000, 8'h12, 8'h34, 10'h046, 4'b1111, 8'h12, 8'h34, 10'h200);

    run_stream("bp", 4, 6, 8'h00);
    tick();
    run_stream("stream", 16, 0, 8'h10);
    tick();

    // Buffer two results, then reset between edges.
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl = 4'b0000; x = 8'h11; y = 8'h01;
    tick();
    x = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("buffered", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {30'd0, in_ready, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("no_stale", seen, 32'd0);
    in_valid = 1'b1; ctrl = 4'b0000; x = 8'h02; y = 8'h03;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("post_rst", {22'd0, out_valid, err, carry, out}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h05});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
